// File: rtl/pa_AsyncCordic.sv
// Shared types and constants for the asynchronous CORDIC datapath.
//   dual_rail_t      : one dual-rail bit, {rail_one, rail_zero}
//   DR_NULL/ZERO/ONE : the legal codes. 2'b11 is illegal.
//   RW               : iteration-counter width. The counter issues RW+2 ctrl tokens per operand.
//   loop_sel_state_e : steering state of async_loop_select
package pa_AsyncCordic;

  typedef logic [1:0] dual_rail_t;

  localparam dual_rail_t DR_NULL = 2'b00;
  localparam dual_rail_t DR_ZERO = 2'b01;
  localparam dual_rail_t DR_ONE  = 2'b10;

  localparam int unsigned RW = 16;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    LOOP = 1'b1
  } loop_sel_state_e;

endpackage

// File: rtl/async_completion_detect.sv
// Completion detector for a dual-rail vector.
//   data_i    : dual_rail_t[SIZE:0] vector under observation
//   all_valid : every bit carries exactly one asserted rail
//   all_null  : every bit is NULL
// Illegal 2'b11 bits count neither as valid nor as null.
module async_completion_detect
  import pa_AsyncCordic::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  dual_rail_t [SIZE:0] data_i,
  output logic                all_valid,
  output logic                all_null
);

  always_comb begin
    all_valid = 1'b1;
    all_null  = 1'b1;
    for (int unsigned i = 0; i <= SIZE; i++) begin
      all_valid &= ^data_i[i];
      all_null  &= ~|data_i[i];
    end
  end

endmodule

// File: rtl/async_loop_select.sv
// Clockless four-phase dual-rail steering stage at the CORDIC loop entry/exit.
// In LOAD it passes a fresh operand into the loop. In LOOP it waits for the counter
// token and the feedback operand. On ONE it recirculates the operand into the loop.
// On ZERO it retires the operand to the result channel and then returns to LOAD.
//   arst        : asynchronous active-low reset. All outputs go NULL/0 and the state goes to LOAD.
//   in_data_i   : fresh operand.                       in_ack_o   : its acknowledge
//   fb_data_i   : feedback operand.                    fb_ack_o   : its acknowledge
//   ctrl_i      : counter token (ONE=continue, ZERO=stop).  ctrl_ack_o : its acknowledge
//   loop_data_o : operand into the iteration stage.    loop_ack_i : its acknowledge
//   res_data_o  : retired operand.                     res_ack_i  : its acknowledge
//   err_o       : sticky illegal-code flag. It exists only when ASYNC_LOOP_SELECT_CHECK_EN is defined.
module async_loop_select
  import pa_AsyncCordic::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic                arst,
  input  dual_rail_t [SIZE:0] in_data_i,
  output logic                in_ack_o,
  input  dual_rail_t [SIZE:0] fb_data_i,
  output logic                fb_ack_o,
  input  dual_rail_t          ctrl_i,
  output logic                ctrl_ack_o,
  output dual_rail_t [SIZE:0] loop_data_o,
  input  logic                loop_ack_i,
  output dual_rail_t [SIZE:0] res_data_o,
  input  logic                res_ack_i
`ifdef ASYNC_LOOP_SELECT_CHECK_EN
  ,
  output logic                err_o
`endif
);

  logic in_valid, in_null, fb_valid, fb_null;
  logic ctrl_valid, ctrl_null, both_valid, both_null;

  async_completion_detect #(.SIZE(SIZE)) u_in_cd (
    .data_i   (in_data_i),
    .all_valid(in_valid),
    .all_null (in_null)
  );

  async_completion_detect #(.SIZE(SIZE)) u_fb_cd (
    .data_i   (fb_data_i),
    .all_valid(fb_valid),
    .all_null (fb_null)
  );

  assign ctrl_valid = (ctrl_i == DR_ZERO) || (ctrl_i == DR_ONE);
  assign ctrl_null  = (ctrl_i == DR_NULL);
  assign both_valid = ctrl_valid & fb_valid;
  assign both_null  = ctrl_null & fb_null;

  loop_sel_state_e state_q, state_d;
  logic load_go_q, sel_cont_q, sel_stop_q, in_ack_q, fc_ack_q, retire_q;
  logic xfer_ack;

  // Every handshake element below is a generalised C-element: a set term, a reset term,
  // and otherwise hold. The set and reset terms of each element never overlap.

  // Opens the LOAD steering path once the fresh operand is complete.
  always_latch begin
    if (!arst)                            load_go_q <= 1'b0;
    else if (state_q == LOAD && in_valid) load_go_q <= 1'b1;
    else if (in_null)                     load_go_q <= 1'b0;
  end

  // Records the LOOP decision. It is held until token and feedback have both returned to NULL.
  always_latch begin
    if (!arst)                                                  sel_cont_q <= 1'b0;
    else if (state_q == LOOP && both_valid && ctrl_i == DR_ONE) sel_cont_q <= 1'b1;
    else if (both_null)                                         sel_cont_q <= 1'b0;
  end

  always_latch begin
    if (!arst)                                                   sel_stop_q <= 1'b0;
    else if (state_q == LOOP && both_valid && ctrl_i == DR_ZERO) sel_stop_q <= 1'b1;
    else if (both_null)                                          sel_stop_q <= 1'b0;
  end

  // Upstream acknowledge: C(loop_ack, completion) gated to the LOAD path.
  always_latch begin
    if (!arst)                          in_ack_q <= 1'b0;
    else if (load_go_q && loop_ack_i)   in_ack_q <= 1'b1;
    else if (!loop_ack_i && in_null)    in_ack_q <= 1'b0;
  end

  // Shared feedback/ctrl acknowledge. It falls only after both channels are NULL and the
  // chosen downstream acknowledge has dropped.
  always_latch begin
    if (!arst)                                                fc_ack_q <= 1'b0;
    else if ((sel_cont_q && loop_ack_i) ||
             (sel_stop_q && res_ack_i))                       fc_ack_q <= 1'b1;
    else if (!loop_ack_i && !res_ack_i && both_null)          fc_ack_q <= 1'b0;
  end

  // The two acks are never high together, so their OR gives exactly one falling edge per transfer.
  assign xfer_ack = in_ack_q | fc_ack_q;

  // Remembers whether the current LOOP transfer is a retirement. It is sampled while the
  // decision is still stable.
  always_ff @(posedge fc_ack_q or negedge arst) begin
    if (!arst) retire_q <= 1'b0;
    else       retire_q <= sel_stop_q;
  end

  // State register. It advances only on the final ack-low edge, when every output is NULL.
  always_ff @(negedge xfer_ack or negedge arst) begin
    if (!arst) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: state_d = LOOP;
      LOOP: if (retire_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    loop_data_o = '0;
    res_data_o  = '0;
    if (state_q == LOAD) begin
      if (load_go_q) loop_data_o = in_data_i;
    end else if (sel_cont_q) begin
      loop_data_o = fb_data_i;
    end
    if (sel_stop_q) res_data_o = fb_data_i;
    in_ack_o   = in_ack_q;
    fb_ack_o   = fc_ack_q;
    ctrl_ack_o = fc_ack_q;
  end

`ifdef ASYNC_LOOP_SELECT_CHECK_EN
  logic illegal, err_q;

  always_comb begin
    illegal = (ctrl_i == 2'b11);
    for (int unsigned i = 0; i <= SIZE; i++) begin
      illegal |= (in_data_i[i] == 2'b11) | (fb_data_i[i] == 2'b11);
    end
  end

  always_latch begin
    if (!arst)        err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign err_o = err_q;
`endif

endmodule
